// File: rtl/systolic_tile_sequencer.sv
// Control sequencer for one K-tile of the 4x4 systolic array: operand reads, feed,
// drain, accumulator capture and optional requantization with a bounded wait.
module systolic_tile_sequencer #(
    parameter int ARRAY_SIZE = 4,
    parameter int K_W        = 8,
    parameter int QTIMEOUT   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    input  logic           accum_keep,
    input  logic           last_tile,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           rd_en,
    output logic [K_W-1:0] rd_addr,
    output logic           zero_feed,
    output logic           arr_enable,
    output logic           accum_clear,
    output logic           accum_enable,
    output logic           quant_enable,
    input  logic           quant_valid
);
    localparam int DRAIN_CYC = 2 * ARRAY_SIZE - 1;
    localparam int DRAIN_W   = $clog2(2 * ARRAY_SIZE);
    localparam int WAIT_W    = $clog2(QTIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(QTIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_ACCUM,
        S_QUANT,
        S_WAIT_Q,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [K_W-1:0]     k_len_reg, k_len_next;
    logic               keep_reg, keep_next;
    logic               last_reg, last_next;
    logic [K_W-1:0]     feed_cnt_reg, feed_cnt_next;
    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;

    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic           err_reg, err_next;
    logic           rd_en_reg, rd_en_next;
    logic [K_W-1:0] rd_addr_reg, rd_addr_next;
    logic           zero_feed_reg, zero_feed_next;
    logic           arr_enable_reg, arr_enable_next;
    logic           accum_clear_reg, accum_clear_next;
    logic           accum_enable_reg, accum_enable_next;
    logic           quant_enable_reg, quant_enable_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            k_len_reg        <= '0;
            keep_reg         <= 1'b0;
            last_reg         <= 1'b0;
            feed_cnt_reg     <= '0;
            drain_cnt_reg    <= '0;
            wait_cnt_reg     <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            rd_en_reg        <= 1'b0;
            rd_addr_reg      <= '0;
            zero_feed_reg    <= 1'b0;
            arr_enable_reg   <= 1'b0;
            accum_clear_reg  <= 1'b0;
            accum_enable_reg <= 1'b0;
            quant_enable_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            k_len_reg        <= k_len_next;
            keep_reg         <= keep_next;
            last_reg         <= last_next;
            feed_cnt_reg     <= feed_cnt_next;
            drain_cnt_reg    <= drain_cnt_next;
            wait_cnt_reg     <= wait_cnt_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            err_reg          <= err_next;
            rd_en_reg        <= rd_en_next;
            rd_addr_reg      <= rd_addr_next;
            zero_feed_reg    <= zero_feed_next;
            arr_enable_reg   <= arr_enable_next;
            accum_clear_reg  <= accum_clear_next;
            accum_enable_reg <= accum_enable_next;
            quant_enable_reg <= quant_enable_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        k_len_next     = k_len_reg;
        keep_next      = keep_reg;
        last_next      = last_reg;
        feed_cnt_next  = feed_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        err_next       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        err_next = 1'b1;
                    end else begin
                        k_len_next = k_len;
                        keep_next  = accum_keep;
                        last_next  = last_tile;
                        state_next = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                feed_cnt_next = '0;
                state_next    = S_FEED;
            end
            S_FEED: begin
                // Counts to k-1 only, so k_len = all-ones never wraps the counter.
                if (feed_cnt_reg == k_len_reg - K_W'(1)) begin
                    drain_cnt_next = '0;
                    state_next     = S_DRAIN;
                end else begin
                    feed_cnt_next = feed_cnt_reg + K_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = S_ACCUM;
                end else begin
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                end
            end
            S_ACCUM: begin
                state_next = last_reg ? S_QUANT : S_DONE;
            end
            S_QUANT: begin
                wait_cnt_next = WAIT_W'(1);
                state_next    = S_WAIT_Q;
            end
            S_WAIT_Q: begin
                if (quant_valid) begin
                    state_next = S_DONE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output strobes are decoded from the upcoming state and registered, so they
    // line up with the state they belong to without any input-to-output path.
    always_comb begin
        busy_next         = (state_next != S_IDLE);
        done_next         = (state_next == S_DONE);
        rd_en_next        = 1'b0;
        rd_addr_next      = rd_addr_reg;
        zero_feed_next    = (state_next == S_DRAIN) || (state_next == S_ACCUM);
        arr_enable_next   = (state_next == S_FEED) || (state_next == S_DRAIN) ||
                            (state_next == S_ACCUM);
        accum_clear_next  = (state_next == S_CLEAR) && !keep_next;
        accum_enable_next = (state_next == S_ACCUM);
        quant_enable_next = (state_next == S_QUANT);

        if (state_next == S_CLEAR) begin
            rd_en_next   = 1'b1;
            rd_addr_next = '0;
        end else if ((state_next == S_FEED) &&
                     (feed_cnt_next != k_len_reg - K_W'(1))) begin
            rd_en_next   = 1'b1;
            rd_addr_next = feed_cnt_next + K_W'(1);
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign rd_en        = rd_en_reg;
    assign rd_addr      = rd_addr_reg;
    assign zero_feed    = zero_feed_reg;
    assign arr_enable   = arr_enable_reg;
    assign accum_clear  = accum_clear_reg;
    assign accum_enable = accum_enable_reg;
    assign quant_enable = quant_enable_reg;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer with a behavioural operand buffer,
// scalar MAC and requant responder standing in for the datapath.
module tb_systolic_tile_sequencer;
    localparam int K_W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           accum_keep;
    logic           last_tile;
    logic           quant_valid;
    logic           busy, done, err, rd_en, zero_feed, arr_enable;
    logic           accum_clear, accum_enable, quant_enable;
    logic [K_W-1:0] rd_addr;

    systolic_tile_sequencer #(.ARRAY_SIZE(4), .K_W(K_W), .QTIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .accum_keep(accum_keep), .last_tile(last_tile),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .zero_feed(zero_feed), .arr_enable(arr_enable), .accum_clear(accum_clear),
        .accum_enable(accum_enable), .quant_enable(quant_enable),
        .quant_valid(quant_valid)
    );

    always #5 clk = ~clk;

    wire [8:0] strobes = {busy, done, err, rd_en, zero_feed, arr_enable,
                          accum_clear, accum_enable, quant_enable};

    int total = 0;
    int bad   = 0;

    // environment state shared with the datapath model
    logic   qv_en = 1'b1;
    int     tile_id = 0;
    logic [4:0] qhist;
    longint acc;
    logic   a_vld;
    int     a_q, b_q, qres;
    int     rd_cnt, rd_max, rd_sum, dp_bad, done_cnt, err_cnt;

    function automatic int fa(int t, int i);
        return ((i * 5 + t * 3) % 17) - 8;
    endfunction

    function automatic int fb(int t, int i);
        return ((i * 3 + t + 7) % 13) - 6;
    endfunction

    function automatic int sat8(longint v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    // Operand buffers (1-cycle read latency), MAC and requant unit
    initial begin
        qhist = '0; quant_valid = 1'b0; acc = 0; a_vld = 1'b0;
        a_q = 0; b_q = 0; qres = 0;
        rd_cnt = 0; rd_max = 0; rd_sum = 0; dp_bad = 0; done_cnt = 0; err_cnt = 0;
        forever begin
            @(posedge clk); #1;
            qhist = {qhist[3:0], quant_enable & qv_en};
            quant_valid = qhist[4];
            if (accum_clear === 1'b1) acc = 0;
            if (arr_enable === 1'b1 && zero_feed === 1'b0) begin
                if (a_vld !== 1'b1) dp_bad++;
                else acc += longint'(a_q * b_q);
            end
            if (quant_enable === 1'b1) qres = sat8(acc >>> 3);
            a_vld = (rd_en === 1'b1);
            if (rd_en === 1'b1) begin
                a_q = fa(tile_id, int'(rd_addr));
                b_q = fb(tile_id, int'(rd_addr));
                rd_cnt++;
                rd_sum += int'(rd_addr);
                if (int'(rd_addr) > rd_max) rd_max = int'(rd_addr);
            end
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; k_len = '0; accum_keep = 1'b0; last_tile = 1'b0;
        repeat (3) tick();
        total++;
        if ({strobes, rd_addr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b req=0", {strobes, rd_addr});
        end
        reset = 1'b0;
        tick();
        total++;
        if (strobes !== '0) begin
            bad++;
            $display("FAIL reset_idle got=%b req=0", strobes);
        end
        $display("test_reset: checked");
    endtask

    task automatic test_last_tile();
        logic [8:0] e;
        logic [K_W-1:0] ea;
        k_len = 8'd3; accum_keep = 1'b0; last_tile = 1'b1; start = 1'b1; tile_id = 0;
        for (int c = 1; c <= 20; c++) begin
            tick(); start = 1'b0;
            e = {c <= 18, c == 18, 1'b0, c <= 3, c >= 5 && c <= 12, c >= 2 && c <= 12,
                 c == 1, c == 12, c == 13};
            ea = (c <= 3) ? K_W'(c - 1) : 8'd2;
            total++;
            if (strobes !== e || rd_addr !== ea) begin
                bad++;
                $display("FAIL last_tile c=%0d got=%b/%0d req=%b/%0d", c, strobes, rd_addr, e, ea);
            end
        end
        // k=3 products: -8*1 + -3*4 + 2*-6 = -32, >>>3 = -4
        total++;
        if (qres !== -4) begin
            bad++;
            $display("FAIL last_tile_requant got=%0d req=-4", qres);
        end
        $display("test_last_tile: k=3 keep=0 last=1 done@18");
    endtask

    task automatic test_keep_no_quant();
        logic [8:0] e;
        k_len = 8'd3; accum_keep = 1'b1; last_tile = 1'b0; start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick(); start = 1'b0;
            e = {c <= 13, c == 13, 1'b0, c <= 3, c >= 5 && c <= 12, c >= 2 && c <= 12,
                 1'b0, c == 12, 1'b0};
            total++;
            if (strobes !== e) begin
                bad++;
                $display("FAIL keep_no_quant c=%0d got=%b req=%b", c, strobes, e);
            end
        end
        $display("test_keep_no_quant: k=3 keep=1 last=0 done@13");
    endtask

    task automatic test_zero_k();
        logic [8:0] e;
        k_len = 8'd0; accum_keep = 1'b0; last_tile = 1'b1; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick(); start = 1'b0;
            e = {1'b0, 1'b0, c == 1, 6'b0};
            total++;
            if (strobes !== e) begin
                bad++;
                $display("FAIL zero_k c=%0d got=%b req=%b", c, strobes, e);
            end
        end
        $display("test_zero_k: err@1 only");
    endtask

    task automatic test_quant_timeout();
        logic [8:0] e;
        qv_en = 1'b0;
        k_len = 8'd3; accum_keep = 1'b0; last_tile = 1'b1; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick(); start = 1'b0;
            e = {c <= 22, c == 22, c == 22, c <= 3, c >= 5 && c <= 12, c >= 2 && c <= 12,
                 c == 1, c == 12, c == 13};
            total++;
            if (strobes !== e) begin
                bad++;
                $display("FAIL quant_timeout c=%0d got=%b req=%b", c, strobes, e);
            end
        end
        qv_en = 1'b1;
        $display("test_quant_timeout: done+err@22");
    endtask

    task automatic test_start_while_busy();
        logic [8:0] e;
        int d0;
        d0 = done_cnt;
        k_len = 8'd3; accum_keep = 1'b1; last_tile = 1'b0; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = (c == 3 || c == 13);
            e = {c <= 13, c == 13, 1'b0, c <= 3, c >= 5 && c <= 12, c >= 2 && c <= 12,
                 1'b0, c == 12, 1'b0};
            total++;
            if (strobes !== e) begin
                bad++;
                $display("FAIL start_busy c=%0d got=%b req=%b", c, strobes, e);
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL start_busy_done_count got=%0d req=1", done_cnt - d0);
        end
        $display("test_start_while_busy: starts at FEED and DONE ignored");
    endtask

    task automatic test_reset_in_drain();
        logic [8:0] e;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        k_len = 8'd3; accum_keep = 1'b0; last_tile = 1'b1; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick(); start = 1'b0;
            reset = (c == 6);
            if (c <= 6)
                e = {1'b1, 1'b0, 1'b0, c <= 3, c >= 5, c >= 2, c == 1, 1'b0, 1'b0};
            else
                e = '0;
            total++;
            if (strobes !== e || (c >= 7 && rd_addr !== '0)) begin
                bad++;
                $display("FAIL reset_drain c=%0d got=%b/%0d req=%b", c, strobes, rd_addr, e);
            end
        end
        total++;
        if (done_cnt !== d0 || err_cnt !== e0) begin
            bad++;
            $display("FAIL reset_drain_pulses done=%0d err=%0d req=0/0", done_cnt - d0, err_cnt - e0);
        end
        $display("test_reset_in_drain: aborted cleanly");
    endtask

    task automatic run_long_tile(input int tid, input logic keep, input logic last,
                                 input int exp_done);
        int c, dc;
        tile_id = tid; rd_cnt = 0; rd_max = 0; rd_sum = 0;
        k_len = 8'd255; accum_keep = keep; last_tile = last; start = 1'b1;
        c = 0; dc = 0;
        while (dc == 0 && c < 400) begin
            tick(); c++; start = 1'b0;
            if (done === 1'b1) dc = c;
        end
        total++;
        if (dc !== exp_done) begin
            bad++;
            $display("FAIL b2b_done_cycle tile=%0d got=%0d req=%0d", tid, dc, exp_done);
        end
        total++;
        if (rd_cnt !== 255 || rd_max !== 254 || rd_sum !== 32385) begin
            bad++;
            $display("FAIL b2b_reads tile=%0d cnt=%0d max=%0d sum=%0d req=255/254/32385",
                     tid, rd_cnt, rd_max, rd_sum);
        end
        $display("tile %0d: k=255 done@%0d reads=%0d max_addr=%0d", tid, dc, rd_cnt, rd_max);
    endtask

    task automatic test_back_to_back();
        longint sum;
        int e0, expq;
        e0 = err_cnt; dp_bad = 0;
        sum = 0;
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 255; i++)
                sum += longint'(fa(t, i) * fb(t, i));
        expq = sat8(sum >>> 3);
        run_long_tile(0, 1'b0, 1'b0, 265);
        tick();
        run_long_tile(1, 1'b1, 1'b1, 270);
        total++;
        if (qres !== expq || dp_bad !== 0) begin
            bad++;
            $display("FAIL b2b_requant got=%0d req=%0d (sum=%0d) bad_feeds=%0d",
                     qres, expq, sum, dp_bad);
        end
        total++;
        if (err_cnt !== e0) begin
            bad++;
            $display("FAIL b2b_err got=%0d req=0", err_cnt - e0);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy got=%b req=0", busy);
        end
        $display("test_back_to_back: requant=%0d", qres);
    endtask

    initial begin
        test_reset();
        test_last_tile();
        tick();
        test_keep_no_quant();
        tick();
        test_zero_k();
        test_quant_timeout();
        tick();
        test_start_while_busy();
        test_reset_in_drain();
        tick();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
